// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run control unit: operating-mode encodings,
// run-control FSM states and the seven-segment glyph table.
package run_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_RUNN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RUNN = 2'd2
  } run_state_t;

  // Active-low glyph for "0", also the display value out of reset.
  localparam logic [6:0] SEG_ZERO = 7'h40;

  // Hex glyph table, active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/run_control_unit_hex7seg.sv
// hex7seg: decodes one 4-bit nibble into an active-low seven-segment glyph.
module hex7seg
  import run_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Pure table lookup; registering happens in the parent.
  always_comb begin
    seg_n = seg_glyph(nibble);
  end

endmodule

// File: rtl/run_control_unit.sv
// run_control_unit: produces a one-cycle CPU clock-enable from halt,
// debounced single-step, free-run and run-N modes, counts issued steps and
// drives DIGITS seven-segment displays from a selectable data channel.
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint that
// stops RUN/RUNN and raises a sticky bp_hit flag.
//
// Handshake note: there is no valid/ready pair here; cpu_en is a qualifier
// pulse, high for exactly one cycle per step and never on two consecutive
// cycles. step_btn is fully asynchronous and is synchronised internally.
module run_control_unit
  import run_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int TICK_CYCLES = 500000,
  parameter int RATE_W      = 4,
  parameter int CNT_W       = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 32,
  parameter int DIGITS      = 8,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic                     step_btn,
  input  logic [RATE_W-1:0]        rate_sel,
  input  logic [CNT_W-1:0]         run_n,
  input  logic                     clr_count,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic [SEL_W-1:0]         ch_sel,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic [CH_W-1:0]          pc,
  input  logic [CH_W-1:0]          bp_addr,
  input  logic                     bp_valid,
  output logic                     bp_hit,
`endif
  output logic                     cpu_en,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     busy,
  output logic [DIGITS*7-1:0]      hex_n,
  output logic [1:0]               state_dbg
);

  localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TICK_MX = (2 ** RATE_W) * TICK_CYCLES;
  localparam int TICK_W  = (TICK_MX > 1) ? $clog2(TICK_MX) : 1;
  localparam int DISP_W  = 4 * DIGITS;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Step button: synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------
  logic [1:0]      btn_sync;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            step_req;

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync <= 2'b00;
      db_level <= 1'b0;
      db_cnt   <= '0;
      step_req <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      step_req <= 1'b0;
      if (btn_sync[1] != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= btn_sync[1];
          db_cnt   <= '0;
          step_req <= btn_sync[1];
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Run-control FSM with tick divider
  // ---------------------------------------------------------------------
  run_state_t       state, state_nx;
  logic             cpu_en_c;
  logic             en_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] period_last;
  logic             tick_hit;
  logic [CNT_W-1:0] remaining;
  logic             runn_lock;
  logic             entry_ok;

  // Compared combinationally so a rate change takes effect immediately;
  // a counter already beyond the new period fires straight away.
  assign period_last = TICK_W'((32'(rate_sel) + 32'd1) * 32'(TICK_CYCLES) - 32'd1);
  assign tick_hit    = (tick_cnt >= period_last);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_match;
  assign bp_match = bp_valid && (pc == bp_addr);
  // A latched breakpoint keeps the unit halted until mode returns to halt.
  assign entry_ok = !bp_hit_q;
  assign bp_hit   = bp_hit_q;
`else
  assign entry_ok = 1'b1;
`endif

  // State register plus the per-state bookkeeping (tick, remaining, lock).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      en_q      <= 1'b0;
      tick_cnt  <= '0;
      remaining <= '0;
      runn_lock <= 1'b0;
    end else begin
      state <= state_nx;
      en_q  <= cpu_en_c;

      if (state == ST_IDLE || tick_hit) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end

      if (state == ST_IDLE && state_nx == ST_RUNN) begin
        remaining <= run_n;
      end else if (state == ST_RUNN && cpu_en_c) begin
        remaining <= remaining - CNT_W'(1);
      end

      // Once a run-N burst ends, mode 11 must be left before another burst.
      if (mode != MODE_RUNN) begin
        runn_lock <= 1'b0;
      end else if (state == ST_RUNN && state_nx == ST_IDLE) begin
        runn_lock <= 1'b1;
      end
    end
  end

  // Next-state and step-enable decode; en_q guarantees a gap between pulses.
  always_comb begin
    state_nx = state;
    cpu_en_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_STEP && step_req && !en_q) begin
          cpu_en_c = 1'b1;
        end
        if (mode == MODE_RUN && entry_ok) begin
          state_nx = ST_RUN;
        end else if (mode == MODE_RUNN && run_n != '0 && !runn_lock && entry_ok) begin
          state_nx = ST_RUNN;
        end
      end
      ST_RUN: begin
        if (mode != MODE_RUN) begin
          state_nx = ST_IDLE;
        end else if (tick_hit && !en_q) begin
          cpu_en_c = 1'b1;
        end
      end
      ST_RUNN: begin
        if (mode != MODE_RUNN) begin
          state_nx = ST_IDLE;
        end else if (tick_hit && !en_q) begin
          cpu_en_c = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
`ifdef RUN_CTRL_BREAKPOINT_EN
    if (state != ST_IDLE && cpu_en_c && bp_match) begin
      state_nx = ST_IDLE;
    end
`endif
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Sticky breakpoint flag, cleared only by halt mode or reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bp_hit_q <= 1'b0;
    end else if (mode == MODE_HALT) begin
      bp_hit_q <= 1'b0;
    end else if (state != ST_IDLE && cpu_en_c && bp_match) begin
      bp_hit_q <= 1'b1;
    end
  end
`endif

  assign cpu_en    = cpu_en_c;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Step counter
  // ---------------------------------------------------------------------
  // Wrapping step counter; a clear beats a coincident step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (clr_count) begin
      cycle_count <= '0;
    end else if (cpu_en_c) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Display path: channel mux -> register -> glyph decode -> register
  // ---------------------------------------------------------------------
  logic [DISP_W-1:0]   disp_nx;
  logic [DISP_W-1:0]   disp_q;
  logic [DIGITS*7-1:0] seg_w;

  // Out-of-range channel selects show zero.
  always_comb begin
    disp_nx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == SEL_W'(k)) begin
        disp_nx = ch_data[k*CH_W +: DISP_W];
      end
    end
  end

  // Capture the selected channel once per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_nx;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (disp_q[d*4 +: 4]),
      .seg_n  (seg_w[d*7 +: 7])
    );
  end

  // Registered segment outputs so the pins are glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hex_n <= {DIGITS{SEG_ZERO}};
    end else begin
      hex_n <= seg_w;
    end
  end

endmodule
